// File: rtl/axi4_bresp_scheduler.sv
// axi4_bresp_scheduler: AXI4 slave B-channel response scheduler.
// Buffers completed writes in a compacting shift queue (index 0 oldest) and
// issues them through a registered B channel in order, out of order (LFSR
// start point) or by QoS. Responses with the same ID always leave in arrival
// order: only the oldest entry of each ID is eligible for selection.
// Build option: define AXI4_BRESP_QOS_EN to store qos and add the QoS arbiter
// (qos_en is then honoured). Without it, cmp_qos and qos_en are ignored.
module axi4_bresp_scheduler #(
  parameter int               ID_WIDTH  = 4,
  parameter int               DEPTH     = 16,
  parameter int               QOS_WIDTH = 4,
  parameter logic [7:0]       LFSR_SEED = 8'hA5
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [1:0]                    mode,
  input  logic                          qos_en,
  input  logic                          cmp_valid,
  output logic                          cmp_ready,
  input  logic [ID_WIDTH-1:0]           cmp_id,
  input  logic [1:0]                    cmp_resp,
  input  logic [QOS_WIDTH-1:0]          cmp_qos,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [ID_WIDTH-1:0]           bid,
  output logic [1:0]                    bresp,
  output logic [$clog2(DEPTH+1):0]      count,
  output logic                          full,
  output logic                          empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);
  localparam int CW = OW + 1;

  // queue storage, packed per entry
  logic [DEPTH-1:0][ID_WIDTH-1:0]  r_id;
  logic [DEPTH-1:0][1:0]           r_resp;
  logic [OW-1:0]                   r_occ;
  logic [7:0]                      r_lfsr;
  logic                            r_bvalid;
  logic [ID_WIDTH-1:0]             r_bid;
  logic [1:0]                      r_bresp;

  logic [DEPTH-1:0]                w_elig;
  logic [IW-1:0]                   w_sel;
  logic [IW-1:0]                   w_start;
  logic                            w_hit;
  logic                            w_enq;
  logic                            w_load;
  logic [OW-1:0]                   w_wr;
  logic                            w_unused;

`ifdef AXI4_BRESP_QOS_EN
  logic [DEPTH-1:0][QOS_WIDTH-1:0] r_qos;
  logic [QOS_WIDTH-1:0]            w_best;
  assign w_unused = &{1'b0, mode[0]};
`else
  assign w_unused = &{1'b0, mode[0], qos_en, cmp_qos};
`endif

  assign full      = (r_occ == OW'(DEPTH));
  assign empty     = (r_occ == '0);
  assign cmp_ready = !full;
  assign w_enq     = cmp_valid && cmp_ready;
  assign w_load    = !empty && (!r_bvalid || bready);
  // a load frees the slot below the youngest, so the new entry lands there
  assign w_wr      = w_load ? (r_occ - OW'(1)) : r_occ;
  assign w_start   = IW'((32'(r_lfsr)) % DEPTH);

  assign bvalid = r_bvalid;
  assign bid    = r_bid;
  assign bresp  = r_bresp;
  assign count  = CW'(r_occ) + CW'(r_bvalid);

  // eligibility: valid and no older entry carries the same id
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_elig[i] = (OW'(i) < r_occ);
      for (int j = 0; j < i; j++)
        if (r_id[j] == r_id[i]) w_elig[i] = 1'b0;
    end
  end

  // selection: QoS (if built and enabled), else LFSR start for OOO, else oldest
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
`ifdef AXI4_BRESP_QOS_EN
    w_best = r_qos[0];
    if (qos_en) begin
      // strict compare keeps the lowest index on ties; entry 0 is always eligible
      for (int i = 1; i < DEPTH; i++)
        if (w_elig[i] && (r_qos[i] > w_best)) begin
          w_sel  = IW'(i);
          w_best = r_qos[i];
        end
    end else
`endif
    if (mode[1]) begin
      for (int i = 0; i < DEPTH; i++)
        if (!w_hit && w_elig[i] && (IW'(i) >= w_start)) begin
          w_sel = IW'(i);
          w_hit = 1'b1;
        end
      // wrap: the first eligible entry from index 0 is always index 0
      if (!w_hit) w_sel = '0;
    end
  end

  // queue: shift out the loaded entry, then write the accepted completion
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id   <= '0;
      r_resp <= '0;
`ifdef AXI4_BRESP_QOS_EN
      r_qos  <= '0;
`endif
      r_occ  <= '0;
    end else begin
      if (w_load) begin
        for (int i = 0; i < DEPTH-1; i++)
          if (IW'(i) >= w_sel) begin
            r_id[i]   <= r_id[i+1];
            r_resp[i] <= r_resp[i+1];
`ifdef AXI4_BRESP_QOS_EN
            r_qos[i]  <= r_qos[i+1];
`endif
          end
      end
      if (w_enq) begin
        r_id[IW'(w_wr)]   <= cmp_id;
        r_resp[IW'(w_wr)] <= cmp_resp;
`ifdef AXI4_BRESP_QOS_EN
        r_qos[IW'(w_wr)]  <= cmp_qos;
`endif
      end
      r_occ <= r_occ + OW'(w_enq) - OW'(w_load);
    end
  end

  // B output register: reload on load, drop valid on a handshake with nothing queued
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= '0;
    end else if (w_load) begin
      r_bvalid <= 1'b1;
      r_bid    <= r_id[w_sel];
      r_bresp  <= r_resp[w_sel];
    end else if (bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // LFSR x^8+x^6+x^5+x^4+1, stepped once per load
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_lfsr <= LFSR_SEED;
    else if (w_load) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

endmodule
